// File: rtl/field_unpacker_pkg.sv
// Shared widths for the field unpacker.
// IN_W: packed word, FIELD_W: field, BUF_W: bit buffer, CNT_W: fill count.
package field_unpacker_pkg;
    localparam int IN_W    = 16;
    localparam int FIELD_W = 5;
    localparam int BUF_W   = 20;
    localparam int CNT_W   = 5;
endpackage

// File: rtl/field_unpacker.sv
// Splits an LSB-first stream of 16-bit words into 5-bit fields.
// Ports: clk, rst_n (async low); in_data/in_valid/in_last/in_ready words in;
//        out_data/out_valid/out_last/out_pad/out_ready fields out.
module field_unpacker
    import field_unpacker_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    output logic [FIELD_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [2:0]         out_pad
);
    localparam logic [CNT_W-1:0] FW  = CNT_W'(FIELD_W);
    localparam logic [CNT_W-1:0] INC = CNT_W'(IN_W);

    logic [BUF_W-1:0]   r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_flush;

    logic               w_in_fire;
    logic               w_out_fire;
    logic [BUF_W-1:0]   w_buf_pop;
    logic [BUF_W-1:0]   w_in_ext;
    logic [BUF_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]   w_cnt_pop;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_flush_nxt;
    logic [FIELD_W-1:0] w_mask;

    // Accept only when a whole word is guaranteed to fit (cnt <= 4).
    assign in_ready  = (r_cnt < FW) && !r_flush;
    assign out_valid = (r_cnt >= FW) || (r_flush && (r_cnt != '0));
    assign out_last  = r_flush && (r_cnt <= FW);
    assign out_pad   = (out_last && (r_cnt < FW)) ? 3'(FW - r_cnt) : 3'd0;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FIELD_W; i++) begin
            w_mask[i] = (CNT_W'(i) < r_cnt);
        end
    end

    assign out_data   = r_buf[FIELD_W-1:0] & w_mask;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Pop first, then append the new word above the surviving bits.
    always_comb begin
        w_buf_pop   = r_buf;
        w_cnt_pop   = r_cnt;
        if (w_out_fire) begin
            w_buf_pop = r_buf >> FIELD_W;
            w_cnt_pop = (r_cnt >= FW) ? (r_cnt - FW) : '0;
        end
        w_in_ext    = BUF_W'(in_data) << w_cnt_pop;
        w_buf_nxt   = w_buf_pop;
        w_cnt_nxt   = w_cnt_pop;
        if (w_in_fire) begin
            w_buf_nxt = w_buf_pop | w_in_ext;
            w_cnt_nxt = w_cnt_pop + INC;
        end
        w_flush_nxt = r_flush;
        if (w_in_fire && in_last) begin
            w_flush_nxt = 1'b1;
        end else if (w_out_fire && (w_cnt_pop == '0)) begin
            w_flush_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
        end else begin
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flush <= w_flush_nxt;
        end
    end
endmodule

// File: tb/tb_field_unpacker.sv
// Randomised and directed bench for field_unpacker against a bit-queue model.
// Drives inputs at posedge+1, compares every cycle at negedge.
module tb_field_unpacker;
    typedef struct packed {
        logic [4:0] d;
        logic       l;
        logic [2:0] p;
    } fld_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  out_pad;

    int errors = 0;
    int checks = 0;
    int or_mode = 0;

    bit   bitq[$];
    fld_t efq[$];
    fld_t lg[$];
    int   acc_log[$];

    field_unpacker dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .out_pad(out_pad)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        int   cnt_m;
        bit   fl_m;
        fld_t f;
        int   n;
        if (!rst_n) begin
            bitq.delete();
            efq.delete();
            chk("reset_outs",
                {out_valid, out_last, out_pad, out_data, in_ready},
                {1'b0, 1'b0, 3'd0, 5'd0, 1'b1});
        end else begin
            cnt_m = bitq.size();
            fl_m  = 0;
            foreach (efq[i]) begin
                cnt_m += 5 - int'(efq[i].p);
                if (efq[i].l) fl_m = 1;
            end
            chk("in_ready", in_ready, (cnt_m <= 4) && !fl_m);
            chk("out_valid", out_valid, efq.size() != 0);
            if (out_valid && efq.size() != 0) begin
                chk("out_data", out_data, efq[0].d);
                chk("out_last", out_last, efq[0].l);
                chk("out_pad", out_pad, efq[0].p);
            end
            chk("cnt_le_20", dut.r_cnt <= 20, 1);
            if (in_valid && in_ready) acc_log.push_back(int'(dut.r_cnt));
            if (out_valid && out_ready) begin
                lg.push_back('{out_data, out_last, out_pad});
                if (efq.size() != 0) void'(efq.pop_front());
            end
            if (in_valid && in_ready) begin
                for (int b = 0; b < 16; b++) bitq.push_back(in_data[b]);
                while (bitq.size() >= 5) begin
                    f = '0;
                    for (int k = 0; k < 5; k++) f.d[k] = bitq.pop_front();
                    efq.push_back(f);
                end
                if (in_last) begin
                    if (bitq.size() > 0) begin
                        n = bitq.size();
                        f = '0;
                        for (int k = 0; k < n; k++) f.d[k] = bitq.pop_front();
                        f.l = 1;
                        f.p = 3'(5 - n);
                        efq.push_back(f);
                    end else begin
                        efq[$].l = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [15:0] d, input bit l);
        int t = 0;
        bit acc = 0;
        in_data = d;
        in_last = l;
        in_valid = 1;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready;
            t++;
            if (!acc) begin
                @(posedge clk);
                #1;
            end
        end
        chk("send_timeout", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((efq.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", t < 1000, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [79:0] v;
        logic [39:0] recon;
        int exp_acc[6] = '{0, 1, 2, 3, 4, 0};
        rst_n = 0;
        in_valid = 0;
        in_data = 0;
        in_last = 0;
        out_ready = 1;
        idle(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1;
        idle(1);

        // five-word frame, exact 80-bit boundary
        lg.delete();
        send(16'hFFFF, 0);
        send(16'h0000, 0);
        send(16'hAAAA, 0);
        send(16'h5555, 0);
        send(16'h1234, 1);
        drain();
        v = {16'h1234, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF};
        chk("a_count", lg.size(), 16);
        if (lg.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("a_data", lg[i].d, v[5*i +: 5]);
                chk("a_last", lg[i].l, i == 15);
            end
            chk("a_pad", lg[15].p, 0);
        end
        chk("a_idle", {out_valid, in_ready}, 2'b01);

        // single word with padded tail
        lg.delete();
        send(16'h8421, 1);
        drain();
        chk("b_count", lg.size(), 4);
        if (lg.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("b_data", lg[i].d, 1);
            chk("b_last", {lg[2].l, lg[3].l}, 2'b01);
            chk("b_pad", lg[3].p, 4);
        end

        // back-to-back fill levels at each accept
        acc_log.delete();
        for (int i = 0; i < 6; i++) send(16'($urandom), i == 5);
        drain();
        chk("c_count", acc_log.size(), 6);
        if (acc_log.size() == 6)
            for (int i = 0; i < 6; i++) chk("c_cnt", acc_log[i], exp_acc[i]);

        // consumer stall for 10 cycles
        lg.delete();
        out_ready = 0;
        send(16'hBEEF, 0);
        repeat (10) begin
            @(negedge clk);
            chk("d_valid", out_valid, 1);
            chk("d_hold", out_data, 5'h0F);
            chk("d_inready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        send(16'h0001, 1);
        drain();
        chk("d_count", lg.size(), 7);
        recon = '0;
        foreach (lg[i]) recon |= 40'(lg[i].d) << (5 * i);
        chk("d_bits", recon[31:0], 32'h0001BEEF);
        if (lg.size() == 7) chk("d_pad", lg[6].p, 3);

        // reset mid-frame with cnt=11 and flush pending
        out_ready = 0;
        send(16'h8421, 1);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk("e_pre_cnt", dut.r_cnt, 11);
        chk("e_pre_flush", dut.r_flush, 1);
        #2;
        rst_n = 0;
        #1;
        chk("e_rst_outs",
            {out_valid, out_last, out_pad, out_data, in_ready},
            {1'b0, 1'b0, 3'd0, 5'd0, 1'b1});
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1;
        lg.delete();
        send(16'h8421, 1);
        drain();
        chk("e_count", lg.size(), 4);
        if (lg.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("e_data", lg[i].d, 1);
            chk("e_pad", lg[3].p, 4);
        end

        // random stalls and frame lengths
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            send(16'($urandom), (i == 299) || ($urandom_range(0, 5) == 0));
        end
        or_mode = 0;
        out_ready = 1;
        drain();
        chk("f_idle", {out_valid, in_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/field_unpacker.md
FIELD_UNPACKER -- requirements
Module: field_unpacker

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_data, input, 16, packed word; bit 0 is the oldest bit.
REQ-004 SHALL have port in_valid, input, 1, in_data/in_last valid.
REQ-005 SHALL have port in_ready, output, 1, unpacker accepts a word this cycle.
REQ-006 SHALL have port in_last, input, 1, word ends a frame; flush the remainder.
REQ-007 SHALL have port out_data, output, 5, extracted field; bit 0 is the oldest bit.
REQ-008 SHALL have port out_valid, output, 1, out_data valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts a field.
REQ-010 SHALL have port out_last, output, 1, final field of the frame.
REQ-011 SHALL have port out_pad, output, 3, count of zero pad bits in the top of out_data (0..4).

Function
REQ-012 SHALL hold a 20-bit bit buffer (buf) plus a 5-bit fill count (cnt, 0..20) and a flush_pend flag.
REQ-013 SHALL treat an input transfer as in_valid and in_ready high on one edge, and an output transfer as out_valid and out_ready high on one edge.
REQ-014 SHALL drive in_ready = (cnt <= 4) and not flush_pend, from registers only, with no path from out_ready.
REQ-015 SHALL drive out_valid = (cnt >= 5) or (flush_pend and cnt > 0).
REQ-016 SHALL drive out_data = buf[4:0], with bits at index >= cnt forced to 0.
REQ-017 SHALL, on an output transfer, shift buf right by 5 (zero fill) and set cnt = max(cnt-5, 0).
REQ-018 SHALL, on an input transfer, write in_data at bit position cnt' (cnt after any same-cycle pop) and add 16 to cnt.
REQ-019 SHALL process a simultaneous input and output transfer in one cycle, with no bit lost or duplicated.
REQ-020 SHALL set flush_pend when in_last is accepted, and clear flush_pend on the output transfer that takes cnt to 0.
REQ-021 SHALL assert out_last when flush_pend and cnt <= 5, including an exact 5-bit boundary where out_pad = 0.
REQ-022 SHALL drive out_pad = 5-cnt when out_last and cnt < 5, else 0.
REQ-023 SHALL hold out_data, out_last and out_pad stable while out_valid is high and out_ready is low.
REQ-024 SHALL make the first field available (out_valid high) the cycle after the first word is accepted.
REQ-025 SHALL never set cnt above 20; an overflow is a design error flagged by a bench assertion.
REQ-026 SHALL drop no bits except an explicitly flushed tail; an unflushed remainder carries into the next word.

Reset
REQ-027 SHALL, while rst_n is low, clear buf, cnt and flush_pend asynchronously, giving out_valid=0, out_last=0, out_pad=0, out_data=0 and in_ready=1.
REQ-028 SHALL discard all buffered bits and any pending flush when reset is asserted mid-frame, with no partial field emitted afterwards.
REQ-029 SHALL release reset synchronously to clk; the first transfer is possible on the first edge after release.

Structure
REQ-030 SHALL place IN_W=16, FIELD_W=5, BUF_W=20 and CNT_W=5 in the shared package field_unpacker_pkg.
REQ-031 SHALL be a single module with no sub-module; the append/shift logic stays inline.
REQ-032 SHALL be a plain register set plus combinational next-state logic, without a separate encoded state machine.

Verification
REQ-033 SHALL cover: five words 0xFFFF, 0x0000, 0xAAAA, 0x5555, 0x1234 with out_ready always high and the last word marked in_last -> exactly 16 fields, bit-exact to the LSB-first split, with out_last on the 16th, out_pad=0 and cnt=0 at the end.
REQ-034 SHALL cover: one word 0x8421 with in_last -> 4 fields 0x01, 0x01, 0x01, 0x01, with out_last on the 4th and out_pad=4.
REQ-035 SHALL cover: out_ready held low for 10 cycles after the first field -> in_ready=0, out_data stable, no bit lost after release.
REQ-036 SHALL cover: the cnt sequence with back-to-back words and full throughput -> cnt after the pops of each word is 1, 2, 3, 4, 0, and in_ready rises each time cnt <= 4.
REQ-037 SHALL cover: rst_n pulsed low with cnt=11 and flush_pend=1 -> all outputs 0 and in_ready=1 immediately, and the next frame unpacks correctly.
REQ-038 SHALL cover: random valid/ready stall patterns against a reference bit-queue model -> bit-exact match, plus the assertion cnt <= 20.
